// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants, types and
// the duty compare used by every LED channel.
package led_pwm_pkg;

  localparam int PWM_BITS       = 8;
  localparam int NUM_CH_DEFAULT = 8;
  localparam int ADDR_BITS      = 3;

  typedef logic [PWM_BITS-1:0] duty_t;

  localparam duty_t DUTY_OFF  = 8'd0;
  localparam duty_t DUTY_FULL = 8'd255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    duty_t                data;
  } duty_wr_t;

  // Full scale is forced on: cnt < 255 alone
  // would drop the last slot of the period.
  function automatic logic pwm_on(
    input duty_t cnt,
    input duty_t duty
  );
    logic on;
    on = 1'b0;
    unique case (1'b1)
      (duty == DUTY_OFF):  on = 1'b0;
      (duty == DUTY_FULL): on = 1'b1;
      default:             on = (cnt < duty);
    endcase
    return on;
  endfunction

endpackage

// File: rtl/led_pwm_driver_if.sv
// led_pwm_driver_if: duty-write handshake
// between the LED register host and the driver.
interface led_pwm_driver_if;
  import led_pwm_pkg::*;

  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  duty_t                wr_data;
  logic                 wr_ack;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );

endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one LED lane with pending and
// active duty plus the registered output gate.
module pwm_channel
  import led_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  duty_t wr_data,
  input  logic  load,
  input  duty_t cnt,
  input  logic  led_in,
  output logic  led_out
);

  duty_t pend_q, pend_d;
  duty_t act_q, act_d;
  logic  led_q, led_d;

  // act takes pend_q, so a write landing on
  // the wrap edge only shows up next period.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (load) begin
      act_d = pend_q;
    end
    if (wr_en) begin
      pend_d = wr_data;
    end
    led_d = led_in & pwm_on(cnt, act_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= DUTY_OFF;
      act_q  <= DUTY_OFF;
      led_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      led_q  <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: prescaled 8-bit PWM for a
// bank of LEDs with period-aligned duty updates.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = 24,
  parameter int NUM_CH   = NUM_CH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] led_in,
  led_pwm_driver_if.slave   bus,
  output logic              period_start,
  output logic [NUM_CH-1:0] led_out
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(PRESCALE - 1);
  localparam duty_t CNT_MAX = '1;

  logic [PW-1:0] pre_q, pre_d;
  duty_t         cnt_q, cnt_d;
  logic          ps_q, ps_d;
  wr_state_e     st_q, st_d;
  logic          ack_q, ack_d;

  logic              tick;
  logic              wrap;
  logic              accept;
  duty_wr_t          req;
  logic [NUM_CH-1:0] ch_we;

  assign req  = '{addr: bus.wr_addr,
                  data: bus.wr_data};
  assign tick = (pre_q == PRE_MAX);
  assign wrap = tick && (cnt_q == CNT_MAX);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
    cnt_d = tick ? cnt_q + duty_t'(1) : cnt_q;
    ps_d  = wrap;
  end

  // ACK burns one cycle, capping accepts at
  // one write every two cycles.
  always_comb begin
    st_d   = st_q;
    ack_d  = 1'b0;
    accept = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (bus.wr_en) begin
          accept = 1'b1;
          ack_d  = 1'b1;
          st_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
      ps_q  <= 1'b0;
      st_q  <= ST_IDLE;
      ack_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
      st_q  <= st_d;
      ack_q <= ack_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_we[g] =
      accept && (int'(req.addr) == g);

    pwm_channel u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (ch_we[g]),
      .wr_data (req.data),
      .load    (wrap),
      .cnt     (cnt_q),
      .led_in  (led_in[g]),
      .led_out (led_out[g])
    );
  end

  assign bus.wr_ack   = ack_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: scoreboard bench for an
// 8-lane fast-tick driver and a 4-lane slow one.
module tb_led_pwm_driver;
  import led_pwm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n = 1'b0;
  logic       rst4_n = 1'b0;
  logic [7:0] led_in8;
  logic [3:0] led_in4;
  logic       ps8, ps4;
  logic [7:0] led8;
  logic [3:0] led4;

  led_pwm_driver_if bus8 ();
  led_pwm_driver_if bus4 ();

  led_pwm_driver #(.PRESCALE(1), .NUM_CH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .led_in(led_in8),
    .bus(bus8), .period_start(ps8), .led_out(led8)
  );

  led_pwm_driver #(.PRESCALE(4), .NUM_CH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .led_in(led_in4),
    .bus(bus4), .period_start(ps4), .led_out(led4)
  );

  int pass_n = 0;
  int total_n = 0;

  // {period_start, wr_ack, led_out} expected after each edge
  logic [9:0] sb[$];
  int         m_cnt;
  bit         m_busy;
  logic [7:0] m_pend[8];
  logic [7:0] m_act[8];

  function automatic bit ref_on(int c, logic [7:0] d);
    if (d == 8'd0) return 1'b0;
    if (d == 8'd255) return 1'b1;
    return c < int'(d);
  endfunction

  always @(posedge clk or negedge rst8_n) begin : model
    logic [7:0] el;
    bit wrp, acc;
    if (!rst8_n) begin
      m_cnt = 0;
      m_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 8'd0;
        m_act[i] = 8'd0;
      end
    end else begin
      for (int i = 0; i < 8; i++)
        el[i] = led_in8[i] & ref_on(m_cnt, m_act[i]);
      wrp = (m_cnt == 255);
      acc = !m_busy && (bus8.wr_en === 1'b1);
      if (wrp)
        for (int i = 0; i < 8; i++) m_act[i] = m_pend[i];
      if (acc) m_pend[bus8.wr_addr] = bus8.wr_data;
      m_busy = acc;
      m_cnt = (m_cnt + 1) % 256;
      sb.push_back({wrp, acc, el});
    end
  end

  task automatic step(output logic [9:0] e, output logic [9:0] g);
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : 10'bx;
    g = {ps8, bus8.wr_ack, led8};
  endtask

  task automatic drive8(input logic en, input logic [2:0] a,
                        input logic [7:0] d);
    bus8.wr_en = en;
    bus8.wr_addr = a;
    bus8.wr_data = d;
  endtask

  task automatic test_reset();
    rst8_n = 1'b0;
    rst4_n = 1'b0;
    led_in8 = 8'hFF;
    led_in4 = 4'hF;
    drive8(1'b0, 3'd0, 8'd0);
    bus4.wr_en = 1'b0;
    bus4.wr_addr = 3'd0;
    bus4.wr_data = 8'd0;
    repeat (3) @(negedge clk);
    total_n++;
    if (led8 !== 8'h00) $display("FAIL rst_led8 got %h want 00", led8);
    else pass_n++;
    total_n++;
    if (ps8 !== 1'b0) $display("FAIL rst_ps8 got %b want 0", ps8);
    else pass_n++;
    total_n++;
    if (bus8.wr_ack !== 1'b0)
      $display("FAIL rst_ack8 got %b want 0", bus8.wr_ack);
    else pass_n++;
    total_n++;
    if ({ps4, bus4.wr_ack, led4} !== 6'd0)
      $display("FAIL rst_dut4 got %b want 000000", {ps4, bus4.wr_ack, led4});
    else pass_n++;
  endtask

  task automatic test_first_tick();
    logic [9:0] e, g;
    int n8 = 0, n4 = 0, bad = 0;
    @(negedge clk);
    rst8_n = 1'b1;
    rst4_n = 1'b1;
    sb.delete();
    for (int n = 1; n <= 1100; n++) begin
      step(e, g);
      if (g !== e) bad++;
      if (g[9] && n8 == 0) n8 = n;
      if (ps4 && n4 == 0) n4 = n;
    end
    total_n++;
    if (n8 !== 256) $display("FAIL first_ps8 got %0d want 256", n8);
    else pass_n++;
    total_n++;
    if (n4 !== 1024) $display("FAIL first_ps4 got %0d want 1024", n4);
    else pass_n++;
    total_n++;
    if (bad !== 0) $display("FAIL first_sb got %0d bad want 0", bad);
    else pass_n++;
  endtask

  task automatic test_duty_128();
    logic [9:0] e, g;
    int bad = 0, hi = 0;
    bit seen = 1'b0;
    @(negedge clk);
    sb.delete();
    led_in8 = 8'h01;
    drive8(1'b1, 3'd0, 8'd128);
    step(e, g); if (g !== e) bad++;
    drive8(1'b0, 3'd0, 8'd0);
    for (int k = 0; k < 600 && !seen; k++) begin
      step(e, g); if (g !== e) bad++;
      seen = g[9];
    end
    total_n++;
    if (seen !== 1'b1) $display("FAIL d128_sync got %b want 1", seen);
    else pass_n++;
    for (int k = 0; k < 256; k++) begin
      step(e, g); if (g !== e) bad++;
      hi += int'(g[0]);
    end
    total_n++;
    if (hi !== 128) $display("FAIL d128_high got %0d want 128", hi);
    else pass_n++;
    total_n++;
    if (bad !== 0) $display("FAIL d128_sb got %0d bad want 0", bad);
    else pass_n++;
  endtask

  task automatic test_full_off();
    logic [9:0] e, g;
    int bad = 0, on3 = 0, off4 = 0;
    bit seen = 1'b0;
    @(negedge clk);
    sb.delete();
    led_in8 = 8'hFF;
    drive8(1'b1, 3'd3, 8'd0);
    step(e, g); if (g !== e) bad++;
    drive8(1'b0, 3'd0, 8'd0);
    step(e, g); if (g !== e) bad++;
    drive8(1'b1, 3'd4, 8'd255);
    step(e, g); if (g !== e) bad++;
    drive8(1'b0, 3'd0, 8'd0);
    for (int k = 0; k < 600 && !seen; k++) begin
      step(e, g); if (g !== e) bad++;
      seen = g[9];
    end
    total_n++;
    if (seen !== 1'b1) $display("FAIL full_sync got %b want 1", seen);
    else pass_n++;
    for (int k = 0; k < 768; k++) begin
      step(e, g); if (g !== e) bad++;
      on3 += int'(g[3]);
      off4 += int'(!g[4]);
    end
    total_n++;
    if (on3 !== 0) $display("FAIL duty0_on got %0d want 0", on3);
    else pass_n++;
    total_n++;
    if (off4 !== 0) $display("FAIL duty255_off got %0d want 0", off4);
    else pass_n++;
    total_n++;
    if (bad !== 0) $display("FAIL full_sb got %0d bad want 0", bad);
    else pass_n++;
  endtask

  task automatic test_mid_write();
    logic [9:0] e, g;
    logic [1:0] ack;
    logic wrapped;
    int bad = 0, hi = 0, hi2 = 0;
    bit seen = 1'b0;
    @(negedge clk);
    sb.delete();
    drive8(1'b1, 3'd2, 8'd200);
    step(e, g); if (g !== e) bad++;
    drive8(1'b0, 3'd0, 8'd0);
    for (int k = 0; k < 600 && !seen; k++) begin
      step(e, g); if (g !== e) bad++;
      seen = g[9];
    end
    repeat (100) begin
      step(e, g); if (g !== e) bad++;
    end
    drive8(1'b1, 3'd2, 8'd64);
    ack = 2'b00;
    wrapped = 1'b0;
    for (int k = 0; k < 156; k++) begin
      step(e, g); if (g !== e) bad++;
      if (k == 0) begin
        ack[0] = g[8];
        drive8(1'b0, 3'd0, 8'd0);
      end
      if (k == 1) ack[1] = g[8];
      hi += int'(g[2]);
      wrapped = g[9];
    end
    total_n++;
    if (ack !== 2'b01) $display("FAIL mid_ack got %b want 01", ack);
    else pass_n++;
    total_n++;
    if (hi !== 100) $display("FAIL mid_old_duty got %0d want 100", hi);
    else pass_n++;
    total_n++;
    if (wrapped !== 1'b1) $display("FAIL mid_wrap got %b want 1", wrapped);
    else pass_n++;
    for (int k = 0; k < 256; k++) begin
      step(e, g); if (g !== e) bad++;
      hi2 += int'(g[2]);
    end
    total_n++;
    if (hi2 !== 64) $display("FAIL mid_new_duty got %0d want 64", hi2);
    else pass_n++;
    total_n++;
    if (bad !== 0 || !seen) $display("FAIL mid_sb got %0d bad want 0", bad);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] e, g;
    logic [4:0] ack;
    int bad = 0, h1 = 0, h2 = 0, h3 = 0, h5 = 0;
    bit seen = 1'b0;
    @(negedge clk);
    sb.delete();
    drive8(1'b1, 3'd1, 8'd10);
    step(e, g); if (g !== e) bad++; ack[0] = g[8];
    drive8(1'b1, 3'd2, 8'd20);
    step(e, g); if (g !== e) bad++; ack[1] = g[8];
    drive8(1'b1, 3'd3, 8'd30);
    step(e, g); if (g !== e) bad++; ack[2] = g[8];
    drive8(1'b1, 3'd5, 8'd50);
    step(e, g); if (g !== e) bad++; ack[3] = g[8];
    drive8(1'b0, 3'd0, 8'd0);
    step(e, g); if (g !== e) bad++; ack[4] = g[8];
    total_n++;
    if (ack !== 5'b00101) $display("FAIL b2b_ack got %b want 00101", ack);
    else pass_n++;
    for (int k = 0; k < 600 && !seen; k++) begin
      step(e, g); if (g !== e) bad++;
      seen = g[9];
    end
    for (int k = 0; k < 256; k++) begin
      step(e, g); if (g !== e) bad++;
      h1 += int'(g[1]);
      h2 += int'(g[2]);
      h3 += int'(g[3]);
      h5 += int'(g[5]);
    end
    total_n++;
    if ({h1, h3} !== {32'd10, 32'd30})
      $display("FAIL b2b_taken got %0d,%0d want 10,30", h1, h3);
    else pass_n++;
    total_n++;
    if ({h2, h5} !== {32'd64, 32'd0})
      $display("FAIL b2b_dropped got %0d,%0d want 64,0", h2, h5);
    else pass_n++;
    total_n++;
    if (bad !== 0 || !seen) $display("FAIL b2b_sb got %0d bad want 0", bad);
    else pass_n++;
  endtask

  task automatic test_addr_drop();
    logic [9:0] e, g;
    logic [3:0] ack;
    int bad = 0;
    bit seen = 1'b0;
    @(negedge clk);
    bus4.wr_en = 1'b1; bus4.wr_addr = 3'd3; bus4.wr_data = 8'd255;
    step(e, g); ack[0] = bus4.wr_ack;
    bus4.wr_en = 1'b0;
    step(e, g); ack[1] = bus4.wr_ack;
    bus4.wr_en = 1'b1; bus4.wr_addr = 3'd7; bus4.wr_data = 8'd0;
    step(e, g); ack[2] = bus4.wr_ack;
    bus4.wr_en = 1'b0;
    step(e, g); ack[3] = bus4.wr_ack;
    total_n++;
    if (ack !== 4'b0101) $display("FAIL drop_ack got %b want 0101", ack);
    else pass_n++;
    for (int k = 0; k < 1100 && !seen; k++) begin
      step(e, g);
      seen = ps4;
    end
    total_n++;
    if (seen !== 1'b1) $display("FAIL drop_sync got %b want 1", seen);
    else pass_n++;
    repeat (2) step(e, g);
    for (int k = 0; k < 20; k++) begin
      step(e, g);
      if (led4 !== 4'b1000) bad++;
    end
    total_n++;
    if (bad !== 0) $display("FAIL drop_led4 got %0d bad want 0", bad);
    else pass_n++;
  endtask

  task automatic test_wrap_write();
    logic [9:0] e, g;
    int bad = 0, hi = 0, hi2 = 0;
    bit seen = 1'b0;
    @(negedge clk);
    sb.delete();
    for (int k = 0; k < 600 && !seen; k++) begin
      step(e, g); if (g !== e) bad++;
      seen = g[9];
    end
    repeat (255) begin
      step(e, g); if (g !== e) bad++;
    end
    drive8(1'b1, 3'd1, 8'd32);
    step(e, g); if (g !== e) bad++;
    drive8(1'b0, 3'd0, 8'd0);
    total_n++;
    if (g[9:8] !== 2'b11) $display("FAIL wrap_coinc got %b want 11", g[9:8]);
    else pass_n++;
    for (int k = 0; k < 256; k++) begin
      step(e, g); if (g !== e) bad++;
      hi += int'(g[1]);
    end
    for (int k = 0; k < 256; k++) begin
      step(e, g); if (g !== e) bad++;
      hi2 += int'(g[1]);
    end
    total_n++;
    if (hi !== 10) $display("FAIL wrap_old got %0d want 10", hi);
    else pass_n++;
    total_n++;
    if (hi2 !== 32) $display("FAIL wrap_new got %0d want 32", hi2);
    else pass_n++;
    total_n++;
    if (bad !== 0 || !seen) $display("FAIL wrap_sb got %0d bad want 0", bad);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    logic [9:0] e, g;
    int bad = 0, acks = 0, n8 = 0, n4 = 0;
    @(negedge clk);
    total_n++;
    if (led8[4] !== 1'b1) $display("FAIL rmid_pre got %b want 1", led8[4]);
    else pass_n++;
    drive8(1'b1, 3'd6, 8'd99);
    @(posedge clk);
    #1;
    total_n++;
    if (bus8.wr_ack !== 1'b1)
      $display("FAIL rmid_accept got %b want 1", bus8.wr_ack);
    else pass_n++;
    rst8_n = 1'b0;
    rst4_n = 1'b0;
    #1;
    total_n++;
    if ({ps8, bus8.wr_ack, led8} !== 10'd0)
      $display("FAIL rmid_async8 got %h want 000", {ps8, bus8.wr_ack, led8});
    else pass_n++;
    total_n++;
    if (led4 !== 4'h0) $display("FAIL rmid_async4 got %h want 0", led4);
    else pass_n++;
    repeat (3) begin
      @(negedge clk);
      acks += int'(bus8.wr_ack === 1'b1);
    end
    drive8(1'b0, 3'd0, 8'd0);
    rst8_n = 1'b1;
    rst4_n = 1'b1;
    sb.delete();
    for (int n = 1; n <= 1100; n++) begin
      step(e, g);
      if (g !== e) bad++;
      acks += int'(g[8] === 1'b1);
      if (g[9] && n8 == 0) n8 = n;
      if (ps4 && n4 == 0) n4 = n;
    end
    total_n++;
    if (acks !== 0) $display("FAIL rmid_noack got %0d want 0", acks);
    else pass_n++;
    total_n++;
    if (n8 !== 256) $display("FAIL rmid_ps8 got %0d want 256", n8);
    else pass_n++;
    total_n++;
    if (n4 !== 1024) $display("FAIL rmid_ps4 got %0d want 1024", n4);
    else pass_n++;
    total_n++;
    if (bad !== 0) $display("FAIL rmid_sb got %0d bad want 0", bad);
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_duty_128();
    test_full_off();
    test_mid_write();
    test_back_to_back();
    test_addr_drop();
    test_wrap_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
